game_step_sched: RTL and testbench

GAME_STEP_SCHED -- requirements
Module: game_step_sched

---
 rtl/game_step_sched.sv | 173 +++++++++++++++++
 tb/tb_game_step_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_step_sched.sv
// game_step_sched: step scheduler for a snake-style game.
// Runs a timed WAIT -> MOVE -> CHECK loop. Each step waits one step period,
// then handshakes a move request and a collision check with the datapath.
// The period shortens with each speed level, down to a floor.
// Optional feature: define HS_TIMEOUT_EN to end the game with hs_err set
// when a handshake goes 1024 cycles without its ack.
module game_step_sched #(
  parameter int unsigned BASE_DIV = 10_000_000,
  parameter int unsigned STEP_DIV = 1_000_000,
  parameter int unsigned MIN_DIV  = 2_000_000
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        speed_up,
  input  logic        move_ack,
  input  logic        check_ack,
  input  logic        collide,
  output logic        move_req,
  output logic        check_req,
  output logic        running,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [15:0] step_cnt,
  output logic        hs_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MOVE,
    S_CHECK,
    S_OVER
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [23:0] load_cur;    // reload value for the current level
  logic [23:0] load_first;  // reload value for a new game (level 0)

  // Step period for a level: BASE_DIV - lvl*STEP_DIV, clamped at MIN_DIV.
  // The subtraction is guarded so a large reduction never wraps around.
  function automatic logic [23:0] period_of(input logic [3:0] lvl);
    logic [31:0] red;
    red = 32'(lvl) * 32'(STEP_DIV);
    if ((red >= 32'(BASE_DIV)) || ((32'(BASE_DIV) - red) < 32'(MIN_DIV)))
      return 24'(MIN_DIV);
    else
      return 24'(32'(BASE_DIV) - red);
  endfunction

  // Counter reload values; the counter runs period-1 down to 0 inclusive.
  always_comb begin
    load_cur   = period_of(level) - 24'd1;
    load_first = period_of(4'd0) - 24'd1;
  end

`ifdef HS_TIMEOUT_EN
  logic [9:0] hs_cnt;
`else
  assign hs_err = 1'b0;
`endif

  // Main FSM: state, step timer, level, step count and all registered outputs.
  // NOTE: non-blocking assignments throughout; when two assignments to the same
  // register happen in one cycle, the later one in program order wins, which is
  // how a start clears level even when speed_up arrives in the same cycle.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      level     <= '0;
      step_cnt  <= '0;
      move_req  <= 1'b0;
      check_req <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
`ifdef HS_TIMEOUT_EN
      hs_cnt    <= '0;
      hs_err    <= 1'b0;
`endif
    end else begin
      // Level rises on speed_up while a game exists; a new period only takes
      // effect at the next counter reload.
      if (speed_up && (state != S_IDLE) && (level != 4'hF))
        level <= level + 4'd1;

      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_WAIT;
            running   <= 1'b1;
            game_over <= 1'b0;
            level     <= '0;
            step_cnt  <= '0;
            cnt       <= load_first;
`ifdef HS_TIMEOUT_EN
            hs_err    <= 1'b0;
`endif
          end
        end

        S_WAIT: begin
          if (!pause) begin
            if (cnt == '0) begin
              state    <= S_MOVE;
              move_req <= 1'b1;
`ifdef HS_TIMEOUT_EN
              hs_cnt   <= '0;
`endif
            end else begin
              cnt <= cnt - 24'd1;
            end
          end
        end

        S_MOVE: begin
          if (move_ack) begin
            state     <= S_CHECK;
            move_req  <= 1'b0;
            check_req <= 1'b1;
`ifdef HS_TIMEOUT_EN
            hs_cnt    <= '0;
          end else if (hs_cnt == 10'h3FF) begin
            state     <= S_OVER;
            move_req  <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b1;
            hs_err    <= 1'b1;
          end else begin
            hs_cnt    <= hs_cnt + 10'd1;
`endif
          end
        end

        S_CHECK: begin
          if (check_ack) begin
            check_req <= 1'b0;
            if (collide) begin
              state     <= S_OVER;
              running   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              state    <= S_WAIT;
              step_cnt <= step_cnt + 16'd1;
              cnt      <= load_cur;
            end
`ifdef HS_TIMEOUT_EN
          end else if (hs_cnt == 10'h3FF) begin
            state     <= S_OVER;
            check_req <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b1;
            hs_err    <= 1'b1;
          end else begin
            hs_cnt    <= hs_cnt + 10'd1;
`endif
          end
        end

        default: begin
          state     <= S_IDLE;
          move_req  <= 1'b0;
          check_req <= 1'b0;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_step_sched.sv
// tb_game_step_sched: directed and randomized bench for game_step_sched,
// compared every cycle against a behavioural model of the game rules.
module tb_game_step_sched;

  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MINP = 8;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_MOVE  = 2;
  localparam int P_CHECK = 3;
  localparam int P_OVER  = 4;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        speed_up = 1'b0;
  logic        move_ack = 1'b0;
  logic        check_ack = 1'b0;
  logic        collide = 1'b0;
  logic        move_req;
  logic        check_req;
  logic        running;
  logic        game_over;
  logic [3:0]  level;
  logic [15:0] step_cnt;
  logic        hs_err;

  game_step_sched #(
    .BASE_DIV(BASE),
    .STEP_DIV(STEP),
    .MIN_DIV (MINP)
  ) dut (
    .clk50    (clk50),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .speed_up (speed_up),
    .move_ack (move_ack),
    .check_ack(check_ack),
    .collide  (collide),
    .move_req (move_req),
    .check_req(check_req),
    .running  (running),
    .game_over(game_over),
    .level    (level),
    .step_cnt (step_cnt),
    .hs_err   (hs_err)
  );

  always #10 clk50 = ~clk50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int ph;        // game phase
  int m_left;    // unpaused cycles still to wait before the move
  int m_level;
  int m_steps;
  int m_wait;    // cycles spent waiting for the current ack
  int m_hs;

  function automatic int period_for(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; m_left = 0; m_level = 0; m_steps = 0; m_wait = 0; m_hs = 0;
  endtask

  task automatic new_game();
    ph = P_WAIT; m_level = 0; m_steps = 0; m_hs = 0; m_left = period_for(0);
  endtask

  task automatic handshake_timeout();
`ifdef HS_TIMEOUT_EN
    m_wait++;
    if (m_wait == 1024) begin
      ph = P_OVER; m_hs = 1;
    end
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int prev;
    int old_level;
    prev = ph;
    old_level = m_level;
    case (ph)
      P_IDLE, P_OVER: if (start) new_game();
      P_WAIT: begin
        if (!pause) begin
          m_left--;
          if (m_left == 0) begin ph = P_MOVE; m_wait = 0; end
        end
      end
      P_MOVE: begin
        if (move_ack) begin ph = P_CHECK; m_wait = 0; end
        else handshake_timeout();
      end
      P_CHECK: begin
        if (check_ack) begin
          if (collide) ph = P_OVER;
          else begin
            m_steps = (m_steps + 1) & 16'hFFFF;
            ph = P_WAIT;
            m_left = period_for(old_level);
          end
        end else handshake_timeout();
      end
      default: ph = P_IDLE;
    endcase
    if (speed_up && prev != P_IDLE && !(start && prev == P_OVER) && m_level < 15)
      m_level++;
  endtask

  task automatic compare_all();
    check("move_req",  32'(move_req),  32'(ph == P_MOVE));
    check("check_req", 32'(check_req), 32'(ph == P_CHECK));
    check("running",   32'(running),   32'(ph == P_WAIT || ph == P_MOVE || ph == P_CHECK));
    check("game_over", 32'(game_over), 32'(ph == P_OVER));
    check("level",     32'(level),     32'(m_level));
    check("step_cnt",  32'(step_cnt),  32'(m_steps));
    check("hs_err",    32'(hs_err),    32'(m_hs));
  endtask

  // Called at a falling edge: drive inputs, clock once, compare at next fall.
  task automatic step(input logic s, input logic p, input logic su,
                      input logic ma, input logic ca, input logic co);
    start = s; pause = p; speed_up = su; move_ack = ma; check_ack = ca; collide = co;
    model_step();
    @(posedge clk50);
    @(negedge clk50);
    compare_all();
  endtask

  // Cycles with acks answering one cycle after each request.
  task automatic run_auto(input int n, input logic p);
    for (int i = 0; i < n; i++)
      step(1'b0, p, 1'b0, logic'(ph == P_MOVE), logic'(ph == P_CHECK), 1'b0);
  endtask

  task automatic run_until(input int target, input string tag);
    bit hit;
    hit = (ph == target);
    for (int i = 0; i < 300 && !hit; i++) begin
      step(logic'(ph == P_OVER || ph == P_IDLE), 1'b0, 1'b0,
           logic'(ph == P_MOVE && target != P_MOVE),
           logic'(ph == P_CHECK && target != P_CHECK), 1'b0);
      hit = (ph == target);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  int first_move;
  bit p_run;

  initial begin
    model_reset();
    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #3 compare_all();
    @(negedge clk50);
    rst_n = 1'b1;

    // First game: start in cycle 1, move request expected in cycle 21
    first_move = -1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 40; k++) begin
      if (move_req && first_move < 0) first_move = k - 1;
      step(1'b0, 1'b0, 1'b0, logic'(ph == P_MOVE), logic'(ph == P_CHECK), 1'b0);
    end
    check("first_move_cycle", 32'(first_move), 32'd21);
    check("step_cnt_after_first", 32'(step_cnt), 32'd1);

    // Speed levels and saturation
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, logic'(ph == P_MOVE), logic'(ph == P_CHECK), 1'b0);
    check("level_after_4", 32'(level), 32'd4);
    run_auto(40, 1'b0);
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 1'b1, logic'(ph == P_MOVE), logic'(ph == P_CHECK), 1'b0);
    check("level_saturated", 32'(level), 32'd15);
    run_auto(30, 1'b0);

    // Pause for 7 cycles in the middle of a wait
    run_until(P_WAIT, "reach_wait");
    run_auto(3, 1'b0);
    run_auto(7, 1'b1);
    run_auto(20, 1'b0);

    // Pause raised during a move: handshake finishes, then timer freezes
    run_until(P_MOVE, "reach_move_pause");
    run_auto(25, 1'b1);
    check("frozen_in_wait", 32'(running && !move_req && !check_req), 32'd1);
    run_auto(20, 1'b0);

    // Collision ends the game; start with speed_up restarts at level 0
    run_until(P_CHECK, "reach_check");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("over_running", 32'(running), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_level", 32'(level), 32'd0);
    run_auto(30, 1'b0);

    // Randomized play
    p_run = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic s, su, ma, ca, co;
      if ($urandom_range(0, 11) == 0) p_run = ~p_run;
      s  = (ph == P_OVER) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      su = ($urandom_range(0, 23) == 0);
      ma = (ph == P_MOVE)  ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      ca = (ph == P_CHECK) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      co = ($urandom_range(0, 5) == 0);
      step(s, p_run, su, ma, ca, co);
    end

    // Move never acknowledged for 1100 cycles
    run_until(P_MOVE, "reach_move_noack");
    for (int i = 0; i < 1100; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-handshake acts without a clock edge
    run_until(P_MOVE, "reach_move_reset");
    #3 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk50);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_auto(30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
